// File: rtl/s2mm_pkg.sv
// s2mm_pkg: shared definitions for the S2MM descriptor scheduler.
//   - software register indices (ps side) and s2mm engine register indices
//   - scheduler FSM state encoding (visible in STATUS bits 26:24)
//   - CMP_HEAD field positions and the byte-count helper
package s2mm_pkg;

  // Software-facing register indices
  localparam logic [7:0] REG_DESC_PUSH = 8'd0;
  localparam logic [7:0] REG_STATUS    = 8'd1;
  localparam logic [7:0] REG_CMP_HEAD  = 8'd2;

  // s2mm engine register indices
  localparam logic [7:0] S2MM_ADDR  = 8'd0;
  localparam logic [7:0] S2MM_ERROR = 8'd2;

  // CMP_HEAD layout
  localparam int CMP_VALID_BIT = 31;
  localparam int CMP_ERR_BIT   = 30;
  localparam int CMP_CNT_W     = 24;

  localparam logic [23:0] BYTE_CNT_MAX = 24'hFF_FFFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PROGRAM = 3'd1,
    ARMED   = 3'd2,
    BUSY    = 3'd3,
    COLLECT = 3'd4,
    PUSH    = 3'd5
  } state_t;

  // Beats to bytes, clamped so a huge packet never wraps the 24-bit field.
  function automatic logic [23:0] beats_to_bytes(input logic [23:0] beats,
                                                 input logic [15:0] bytes_per_beat);
    logic [39:0] prod;
    prod = {16'd0, beats} * {24'd0, bytes_per_beat};
    if (prod > {16'd0, BYTE_CNT_MAX}) begin
      beats_to_bytes = BYTE_CNT_MAX;
    end else begin
      beats_to_bytes = prod[23:0];
    end
  endfunction

endpackage

// File: rtl/ps_if.sv
// ps_if: simple register port (write: waddr/wdata/wvalid -> wready/wresp,
// read: raddr/arvalid -> rvalid/rdata). Master issues, slave responds.
interface ps_if;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic        wresp;
  logic [7:0]  raddr;
  logic        arvalid;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output waddr, wdata, wvalid, raddr, arvalid,
                  input  wready, wresp, rvalid, rdata);
  modport slave  (input  waddr, wdata, wvalid, raddr, arvalid,
                  output wready, wresp, rvalid, rdata);
endinterface

// File: rtl/s2mm_desc_sched_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through output.
// Ports: clk, rst_n (sync, active-low), push/din, pop/dout, full, empty, count.
// Push when full and pop when empty are ignored; simultaneous push and pop
// leave count unchanged.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == {CW{1'b0}});
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage (contents are don't-care while empty, so no reset)
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/s2mm_desc_sched.sv
// s2mm_desc_sched: feeds buffer addresses from a descriptor FIFO to an s2mm
// engine one packet at a time, counts the packet's beats by monitoring the
// stream, reads back the engine's error flag and queues a completion record.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   ps_i  (slave)         software regs: 0 DESC_PUSH, 1 STATUS, 2 CMP_HEAD
//   ctl_o (master)        s2mm engine register port
//   tap_valid/ready/last  monitor of the s2mm input stream
//   gate_o                stream enable (high only while a descriptor is armed)
//   irq_o                 high while the completion FIFO holds records
module s2mm_desc_sched
  import s2mm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DESC_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  ps_if.slave  ps_i,
  ps_if.master ctl_o,
  input  logic tap_valid,
  input  logic tap_ready,
  input  logic tap_last,
  output logic gate_o,
  output logic irq_o
);

  localparam int          CW             = $clog2(DESC_DEPTH) + 1;
  localparam logic [15:0] BYTES_PER_BEAT = 16'(DATA_WIDTH / 8);

  state_t        r_state;
  state_t        w_next_state;
  logic          r_wresp;
  logic          r_ovf;
  logic [23:0]   r_beats;
  logic [31:0]   r_addr;
  logic          r_err;
  logic          r_wvalid;
  logic          r_arvalid;
  logic          r_gate;

  logic          w_hs;
  logic          w_wr_push;
  logic          w_desc_push, w_desc_pop, w_desc_full, w_desc_empty;
  logic [31:0]   w_desc_dout;
  logic [CW-1:0] w_desc_count;
  logic          w_cmp_push, w_cmp_pop, w_cmp_full, w_cmp_empty;
  logic [24:0]   w_cmp_din, w_cmp_dout;
  logic [CW-1:0] w_cmp_count;
  logic [31:0]   w_status, w_cmp_head, w_rdata;
  logic          w_unused;

  assign w_hs        = tap_valid & tap_ready;
  assign w_wr_push   = ps_i.wvalid & (ps_i.waddr == REG_DESC_PUSH);
  assign w_desc_push = w_wr_push & ~w_desc_full;
  assign w_cmp_pop   = ps_i.wvalid & (ps_i.waddr == REG_CMP_HEAD) & ~w_cmp_empty;
  assign w_cmp_din   = {r_err, beats_to_bytes(r_beats, BYTES_PER_BEAT)};

  sync_fifo #(.WIDTH(32), .DEPTH(DESC_DEPTH)) u_desc_fifo (
    .clk(clk), .rst_n(rst_n), .push(w_desc_push), .din(ps_i.wdata),
    .pop(w_desc_pop), .dout(w_desc_dout), .full(w_desc_full),
    .empty(w_desc_empty), .count(w_desc_count)
  );

  sync_fifo #(.WIDTH(25), .DEPTH(DESC_DEPTH)) u_cmp_fifo (
    .clk(clk), .rst_n(rst_n), .push(w_cmp_push), .din(w_cmp_din),
    .pop(w_cmp_pop), .dout(w_cmp_dout), .full(w_cmp_full),
    .empty(w_cmp_empty), .count(w_cmp_count)
  );

  // Software register port: write handshake and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wresp <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wresp <= ps_i.wvalid;
      if (w_wr_push && w_desc_full) begin
        r_ovf <= 1'b1;
      end else if (ps_i.wvalid && (ps_i.waddr == REG_STATUS)) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Read-data mux
  always_comb begin
    w_status = {5'd0, r_state, 4'd0, 4'(w_cmp_count), 4'd0, 4'(w_desc_count),
                5'd0, r_ovf, w_desc_full, w_desc_empty};
    w_cmp_head = 32'd0;
    if (!w_cmp_empty) begin
      w_cmp_head[CMP_VALID_BIT]   = 1'b1;
      w_cmp_head[CMP_ERR_BIT]     = w_cmp_dout[24];
      w_cmp_head[CMP_CNT_W-1:0]   = w_cmp_dout[23:0];
    end else begin
      w_cmp_head = 32'd0;
    end
    case (ps_i.raddr)
      REG_STATUS:   w_rdata = w_status;
      REG_CMP_HEAD: w_rdata = w_cmp_head;
      default:      w_rdata = 32'd0;
    endcase
  end

  assign ps_i.wready = 1'b1;
  assign ps_i.wresp  = r_wresp;
  assign ps_i.rvalid = ps_i.arvalid;
  assign ps_i.rdata  = w_rdata;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state and FIFO strobes
  always_comb begin
    w_next_state = r_state;
    w_desc_pop   = 1'b0;
    w_cmp_push   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_desc_empty) begin
          w_desc_pop   = 1'b1;
          w_next_state = PROGRAM;
        end else begin
          w_next_state = IDLE;
        end
      end
      PROGRAM: begin
        if (ctl_o.wresp) w_next_state = ARMED;
        else             w_next_state = PROGRAM;
      end
      ARMED: begin
        if (w_hs) w_next_state = tap_last ? COLLECT : BUSY;
        else      w_next_state = ARMED;
      end
      BUSY: begin
        if (w_hs && tap_last) w_next_state = COLLECT;
        else                  w_next_state = BUSY;
      end
      COLLECT: begin
        if (r_arvalid && ctl_o.rvalid) w_next_state = PUSH;
        else                           w_next_state = COLLECT;
      end
      PUSH: begin
        if (!w_cmp_full) begin
          w_cmp_push   = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_next_state = PUSH;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Registered engine requests, stream gate, beat counter and captured error.
  // Requests are decoded from the next state so they line up with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_gate    <= 1'b0;
      r_addr    <= 32'd0;
      r_beats   <= 24'd0;
      r_err     <= 1'b0;
    end else begin
      r_wvalid  <= (r_state == IDLE) && (w_next_state == PROGRAM);
      r_arvalid <= (w_next_state == COLLECT);
      r_gate    <= (w_next_state == ARMED) || (w_next_state == BUSY);
      if (w_desc_pop) r_addr <= w_desc_dout;
      case (r_state)
        ARMED:   r_beats <= w_hs ? 24'd1 : 24'd0;
        BUSY: begin
          if (w_hs && (r_beats != BYTE_CNT_MAX)) r_beats <= r_beats + 24'd1;
        end
        default: r_beats <= r_beats;
      endcase
      if ((r_state == COLLECT) && r_arvalid && ctl_o.rvalid) r_err <= ctl_o.rdata[0];
    end
  end

  assign ctl_o.waddr   = S2MM_ADDR;
  assign ctl_o.wdata   = r_addr;
  assign ctl_o.wvalid  = r_wvalid;
  assign ctl_o.raddr   = S2MM_ERROR;
  assign ctl_o.arvalid = r_arvalid;
  assign gate_o        = r_gate;
  assign irq_o         = ~w_cmp_empty;

  // Engine write-ready and upper error-register bits carry no information here
  assign w_unused = &{1'b0, ctl_o.wready, ctl_o.rdata[31:1]};

endmodule
